// File: rtl/fp_mac_pkg.sv
// Shared definitions for the MAC floating-point datapath: default field widths,
// aligned-mantissa width and exponent decoding helpers.
package fp_mac_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int GRS_W     = 3;

  // Wide enough for any supported exponent; slice down to EXP_W at the use site.
  localparam logic [30:0] EXP_ALL_ONES = '1;

  // Aligned mantissa is {hidden, fraction, guard, round, sticky}.
  function automatic int aligned_w(input int man_w);
    return man_w + GRS_W + 1;
  endfunction

  // Subnormals (exponent 0) behave as exponent 1 with no hidden bit.
  function automatic logic [30:0] eff_exp(input logic [30:0] ex);
    return (ex == '0) ? 31'd1 : ex;
  endfunction

  function automatic logic hidden_bit(input logic [30:0] ex);
    return |ex;
  endfunction

endpackage

// File: rtl/fp_add_align_pipe_shift_sticky.sv
// Combinational right shift that folds every bit shifted out into bit 0 (sticky).
module fp_shift_sticky #(
  parameter int AW   = 27,
  parameter int SH_W = 5
) (
  input  logic [AW-1:0]   din,
  input  logic [SH_W-1:0] shamt,
  output logic [AW-1:0]   dout
);

  logic [AW-1:0] shifted;
  logic [AW-1:0] lost_mask;
  logic          sticky;

  // A shift of AW or more leaves shifted at zero and makes the mask all ones,
  // so the saturating case collapses to {zeros, OR(din)} without a special path.
  assign shifted   = din >> shamt;
  assign lost_mask = ~({AW{1'b1}} << shamt);
  assign sticky    = |(din & lost_mask);
  assign dout      = {shifted[AW-1:1], shifted[0] | sticky};

endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage valid/ready alignment front end for the FP adder: magnitude compare
// and swap in stage 1, sticky-preserving mantissa alignment in stage 2.
module fp_add_align_pipe
  import fp_mac_pkg::*;
#(
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  localparam int AW    = aligned_w(MAN_W)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             s_a,
  input  logic             s_b,
  input  logic [EXP_W-1:0] ex_a,
  input  logic [EXP_W-1:0] ex_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_big,
  output logic             sign_small,
  output logic             eff_sub,
  output logic [EXP_W-1:0] current_ex,
  output logic [AW-1:0]    man_big,
  output logic [AW-1:0]    man_small,
  output logic             special,
  output logic             a_is_big
);

  localparam int SH_W = $clog2(AW + 1);

  logic v1, v2;
  logic adv2, take_in, load1, load2;

  assign adv2      = ~v2 | out_ready;
  assign in_ready  = ~v1 | adv2;
  assign take_in   = in_valid & in_ready;
  assign load1     = take_in & ~flush;
  assign load2     = v1 & adv2;
  assign out_valid = v2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (load1)      v1 <= 1'b1;
      else if (load2) v1 <= 1'b0;
      if (load2)          v2 <= 1'b1;
      else if (out_ready) v2 <= 1'b0;
    end
  end

  // ---- stage 0 -> 1: decode, magnitude compare, swap ----
  logic [EXP_W-1:0] ea_eff, eb_eff;
  logic             hid_a, hid_b, a_big, sb_eff, special_c;

  assign ea_eff    = EXP_W'(eff_exp(31'(ex_a)));
  assign eb_eff    = EXP_W'(eff_exp(31'(ex_b)));
  assign hid_a     = hidden_bit(31'(ex_a));
  assign hid_b     = hidden_bit(31'(ex_b));
  assign sb_eff    = s_b ^ op_sub;
  assign a_big     = (ex_a > ex_b) || ((ex_a == ex_b) && (man_a >= man_b));
  assign special_c = (ex_a == EXP_ALL_ONES[EXP_W-1:0]) || (ex_b == EXP_ALL_ONES[EXP_W-1:0]);

  logic             a_big_p1, s_big_p1, s_small_p1, special_p1;
  logic [EXP_W-1:0] ex_big_p1, diff_p1;
  logic [MAN_W:0]   man_big_p1, man_small_p1;

  always_ff @(posedge clock) begin
    if (take_in) begin
      a_big_p1   <= a_big;
      special_p1 <= special_c;
      if (a_big) begin
        s_big_p1     <= s_a;
        s_small_p1   <= sb_eff;
        ex_big_p1    <= ea_eff;
        diff_p1      <= ea_eff - eb_eff;
        man_big_p1   <= {hid_a, man_a};
        man_small_p1 <= {hid_b, man_b};
      end else begin
        s_big_p1     <= sb_eff;
        s_small_p1   <= s_a;
        ex_big_p1    <= eb_eff;
        diff_p1      <= eb_eff - ea_eff;
        man_big_p1   <= {hid_b, man_b};
        man_small_p1 <= {hid_a, man_a};
      end
    end
  end

  // ---- stage 1 -> 2: clamp shift and align small mantissa ----
  logic [SH_W-1:0] shift_c;
  logic [AW-1:0]   aligned_c;

  assign shift_c = (32'(diff_p1) >= AW) ? SH_W'(AW) : SH_W'(diff_p1);

  fp_shift_sticky #(
    .AW   (AW),
    .SH_W (SH_W)
  ) u_shift (
    .din   ({man_small_p1, 3'b000}),
    .shamt (shift_c),
    .dout  (aligned_c)
  );

  logic             a_big_p2, s_big_p2, s_small_p2, eff_sub_p2, special_p2;
  logic [EXP_W-1:0] ex_p2;
  logic [AW-1:0]    man_big_p2, man_small_p2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_big_p2     <= 1'b0;
      s_big_p2     <= 1'b0;
      s_small_p2   <= 1'b0;
      eff_sub_p2   <= 1'b0;
      special_p2   <= 1'b0;
      ex_p2        <= '0;
      man_big_p2   <= '0;
      man_small_p2 <= '0;
    end else if (load2) begin
      a_big_p2     <= a_big_p1;
      s_big_p2     <= s_big_p1;
      s_small_p2   <= s_small_p1;
      eff_sub_p2   <= s_big_p1 ^ s_small_p1;
      special_p2   <= special_p1;
      ex_p2        <= ex_big_p1;
      man_big_p2   <= {man_big_p1, 3'b000};
      man_small_p2 <= aligned_c;
    end
  end

  assign a_is_big   = a_big_p2;
  assign sign_big   = s_big_p2;
  assign sign_small = s_small_p2;
  assign eff_sub    = eff_sub_p2;
  assign special    = special_p2;
  assign current_ex = ex_p2;
  assign man_big    = man_big_p2;
  assign man_small  = man_small_p2;

endmodule

// File: tb/tb_fp_add_align_pipe.sv
// Scoreboard bench for fp_add_align_pipe: expected results are queued at input
// acceptance and compared, in order, when the pipeline hands a result downstream.
module tb_fp_add_align_pipe;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic        s_a = 1'b0, s_b = 1'b0;
  logic [7:0]  ex_a = '0, ex_b = '0;
  logic [22:0] man_a = '0, man_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_big, sign_small, eff_sub, special, a_is_big;
  logic [7:0]  current_ex;
  logic [26:0] man_big, man_small;

  fp_add_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .s_a(s_a), .s_b(s_b), .ex_a(ex_a), .ex_b(ex_b), .man_a(man_a), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .eff_sub(eff_sub),
    .current_ex(current_ex), .man_big(man_big), .man_small(man_small),
    .special(special), .a_is_big(a_is_big)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        abig;
    logic        sbig;
    logic        ssmall;
    logic        esub;
    logic        special;
    logic [7:0]  cex;
    logic [26:0] mbig;
    logic [26:0] msmall;
  } res_t;

  res_t q[$];
  res_t exp_r, snap;
  logic stalled = 1'b0;
  int   n_checks = 0, n_pass = 0, n_acc = 0, n_out = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Reference alignment written from the arithmetic definition: loop-built sticky.
  function automatic res_t model(input logic op, input logic sa, input logic [7:0] ea,
                                 input logic [22:0] ma, input logic sb, input logic [7:0] eb,
                                 input logic [22:0] mb);
    res_t r;
    logic sbe;
    int effa, effb, d;
    logic [63:0] ms, sh;
    sbe = sb ^ op;
    effa = (ea == 0) ? 1 : int'(ea);
    effb = (eb == 0) ? 1 : int'(eb);
    r.abig = ({ea, ma} >= {eb, mb});
    if (r.abig) begin
      r.sbig = sa; r.ssmall = sbe; r.cex = 8'(effa);
      r.mbig = {ea != 0, ma, 3'b000};
      ms = {37'b0, eb != 0, mb, 3'b000};
      d = effa - effb;
    end else begin
      r.sbig = sbe; r.ssmall = sa; r.cex = 8'(effb);
      r.mbig = {eb != 0, mb, 3'b000};
      ms = {37'b0, ea != 0, ma, 3'b000};
      d = effb - effa;
    end
    if (d >= 27) sh = 64'(ms != 0);
    else begin
      sh = ms >> d;
      for (int i = 0; i < d; i++) if (ms[i]) sh[0] = 1'b1;
    end
    r.msmall  = sh[26:0];
    r.esub    = r.sbig ^ r.ssmall;
    r.special = (ea == 8'hFF) || (eb == 8'hFF);
    return r;
  endfunction

  function automatic res_t cur();
    res_t r;
    r = {a_is_big, sign_big, sign_small, eff_sub, special, current_ex, man_big, man_small};
    return r;
  endfunction

  always @(negedge clock) begin
    #1;
    if (!resetn) stalled = 1'b0;
    else begin
      if (stalled) check("stall_stable", 128'(cur()), 128'(snap));
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) check("unexpected_out", 128'(1), 128'(0));
        else begin
          exp_r = q.pop_front();
          check("a_is_big",   128'(a_is_big),   128'(exp_r.abig));
          check("sign_big",   128'(sign_big),   128'(exp_r.sbig));
          check("sign_small", 128'(sign_small), 128'(exp_r.ssmall));
          check("eff_sub",    128'(eff_sub),    128'(exp_r.esub));
          check("special",    128'(special),    128'(exp_r.special));
          check("current_ex", 128'(current_ex), 128'(exp_r.cex));
          check("man_big",    128'(man_big),    128'(exp_r.mbig));
          check("man_small",  128'(man_small),  128'(exp_r.msmall));
        end
      end
      stalled = out_valid && !out_ready && !flush;
      snap = cur();
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(model(op_sub, s_a, ex_a, man_a, s_b, ex_b, man_b));
        n_acc++;
      end
    end
  end

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    @(negedge clock);
    op_sub = op;
    s_a = a[31]; ex_a = a[30:23]; man_a = a[22:0];
    s_b = b[31]; ex_b = b[30:23]; man_b = b[22:0];
    in_valid = 1'b1;
    #2;
    while (!in_ready && t < 100) begin
      @(negedge clock); #2; t++;
    end
    if (t >= 100) check("send_timeout", 128'(1), 128'(0));
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clock); t++;
    end
    @(negedge clock);
    check("drain", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int out0, acc0;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clock);
    #1;
    check("rst_outputs", 128'(cur()), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock); #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;

    // equal exponents, B bigger, with latency check
    send(1'b0, 32'h3F800000, 32'h3FC00000);
    idle();
    #1 check("latency_c1", 128'(out_valid), 128'(0));
    @(negedge clock); #1;
    check("latency_c2", 128'(out_valid), 128'(1));
    drain();

    // diff=2 subtract, saturating shifts, subnormal, special, exact tie
    send(1'b1, 32'h3F800000, 32'h3E800000);
    send(1'b0, 32'h3F800000, 32'h30800001);
    send(1'b0, 32'h3F800000, 32'h00000000);
    send(1'b0, 32'h00000001, 32'h00800000);
    send(1'b0, 32'h7F800000, 32'h3F800000);
    send(1'b1, 32'hBF800000, 32'hBF800000);
    idle();
    drain();

    // backpressure: 4 pairs, out_ready low for 3 cycles
    out_ready = 1'b0;
    out0 = n_out;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(1'(i), 32'h40000000 + 32'(i * 7), 32'h3F000000 + 32'(i << 21));
        idle();
      end
      begin
        repeat (3) @(negedge clock);
        #1;
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_accepted", 128'(n_acc - acc0), 128'(2));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 128'(n_out - out0), 128'(4));

    // random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = $urandom;
          rb = $urandom;
          if (i % 2 == 1) rb[30:23] = ra[30:23] + 8'($urandom_range(0, 30));
          if (i % 5 == 0) ra[30:23] = 8'h00;
          send(1'($urandom_range(0, 1)), ra, rb);
        end
        idle();
      end
      begin
        repeat (80) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with two items in flight
    out_ready = 1'b0;
    send(1'b0, 32'h3F800000, 32'h3E800000);
    send(1'b0, 32'h40400000, 32'h3F800000);
    @(posedge clock); #2;
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_outputs", 128'(cur()), 128'(0));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    q.delete();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("postrst_out_valid", 128'(out_valid), 128'(0));
    end
    check("postrst_in_ready", 128'(in_ready), 128'(1));

    // flush together with in_valid drops the input
    @(negedge clock);
    op_sub = 1'b0; s_a = 1'b0; s_b = 1'b0;
    ex_a = 8'd127; ex_b = 8'd126; man_a = '0; man_b = '0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("flush_out_valid", 128'(out_valid), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
